// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int DEFAULT_SIZE = 3;
endpackage

// File: rtl/down_counter_core.sv
// Loadable down counter that saturates at zero and flags when it sits at zero.
module down_counter_core
  import down_timer_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SIZE-1:0] load_val_i,
  input  logic            dec_i,
  output logic [SIZE-1:0] cnt_o,
  output logic            zero_o
);

  logic [SIZE-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);
  assign cnt_o  = cnt_q;

  // Decrement is ignored at zero so the count never wraps to all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && !zero_o)
      cnt_d = cnt_q - SIZE'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/down_timer.sv
// Cascadable one-shot / auto-reload down timer.
// Define DOWN_TIMER_STICKY_DONE_EN to hold done until the next start, ld or reset.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] PI,
  input  logic            ld,
  input  logic            en,
  input  logic            borrowIn,
  input  logic            start,
  input  logic            mode,
  output logic [SIZE-1:0] PO,
  output logic            borrowOut,
  output logic            busy,
  output logic            done
);

  state_t          state_q;
  logic [SIZE-1:0] reload_q;
  logic            done_q;

  logic            dec_evt, term_evt, cnt_zero;
  logic            core_load;
  logic [SIZE-1:0] core_val;

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign dec_evt   = busy && en && borrowIn && !ld;
  // A restart in the same cycle takes precedence over reaching terminal count.
  assign term_evt  = dec_evt && cnt_zero && !start;
  assign borrowOut = busy && en && borrowIn && cnt_zero;

  assign core_load = ld || start || (term_evt && mode);
  assign core_val  = ld ? PI : reload_q;

  down_counter_core #(.SIZE(SIZE)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (core_load),
    .load_val_i(core_val),
    .dec_i     (dec_evt && !start),
    .cnt_o     (PO),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      if (ld)
        reload_q <= PI;

      if (start)
        state_q <= RUN;
      else if (term_evt && !mode)
        state_q <= IDLE;

`ifdef DOWN_TIMER_STICKY_DONE_EN
      if (start || ld)
        done_q <= 1'b0;
      else if (term_evt)
        done_q <= 1'b1;
`else
      done_q <= term_evt;
`endif
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed-vector bench for down_timer, including a two-stage cascade.
module tb_down_timer;
  localparam int SIZE = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [SIZE-1:0] PI = '0;
  logic            ld = 1'b0, en = 1'b0, borrowIn = 1'b0, start = 1'b0, mode = 1'b0;
  logic [SIZE-1:0] PO;
  logic            borrowOut, busy, done;

  logic [SIZE-1:0] c_PI = '0;
  logic            c_ld = 1'b0, c_start = 1'b0, c_en = 1'b0;
  logic [SIZE-1:0] lo_PO, hi_PO;
  logic            lo_bo, hi_bo, lo_busy, hi_busy, lo_done, hi_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  down_timer #(.SIZE(SIZE)) u_dut (
    .clk(clk), .rst(rst), .PI(PI), .ld(ld), .en(en), .borrowIn(borrowIn),
    .start(start), .mode(mode), .PO(PO), .borrowOut(borrowOut), .busy(busy), .done(done)
  );

  down_timer #(.SIZE(SIZE)) u_lo (
    .clk(clk), .rst(rst), .PI(c_PI), .ld(c_ld), .en(c_en), .borrowIn(1'b1),
    .start(c_start), .mode(1'b1), .PO(lo_PO), .borrowOut(lo_bo), .busy(lo_busy), .done(lo_done)
  );

  down_timer #(.SIZE(SIZE)) u_hi (
    .clk(clk), .rst(rst), .PI(c_PI), .ld(c_ld), .en(c_en), .borrowIn(lo_bo),
    .start(c_start), .mode(1'b0), .PO(hi_PO), .borrowOut(hi_bo), .busy(hi_busy), .done(hi_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int po, input int bz, input int dn);
    check({tag, ".PO"}, int'(PO), po);
    check({tag, ".busy"}, int'(busy), bz);
    check({tag, ".done"}, int'(done), dn);
  endtask

  initial begin
    #2;
    expect_state("reset", 0, 0, 0);
    check("reset.borrowOut", int'(borrowOut), 0);
    @(negedge clk);
    rst = 1'b1;

    // One-shot from 3
    tick();
    PI = 3'd3; ld = 1'b1;
    tick();
    expect_state("os.load", 3, 0, 0);
    ld = 1'b0; start = 1'b1; mode = 1'b0; en = 1'b1; borrowIn = 1'b1;
    tick();
    expect_state("os.start", 3, 1, 0);
    start = 1'b0;
    tick(); expect_state("os.2", 2, 1, 0);
    tick(); expect_state("os.1", 1, 1, 0);
    tick(); expect_state("os.0", 0, 1, 0);
    check("os.borrowOut", int'(borrowOut), 1);
    tick(); expect_state("os.term", 0, 0, 1);
    tick();
`ifdef DOWN_TIMER_STICKY_DONE_EN
    expect_state("os.after", 0, 0, 1);
`else
    expect_state("os.after", 0, 0, 0);
`endif
    check("os.idle.borrowOut", int'(borrowOut), 0);

    // Auto-reload from 2, loaded and started together
    PI = 3'd2; ld = 1'b1; start = 1'b1; mode = 1'b1;
    tick(); expect_state("ar.start", 2, 1, 0);
    ld = 1'b0; start = 1'b0;
    tick(); expect_state("ar.1a", 1, 1, 0);
    tick(); expect_state("ar.0a", 0, 1, 0);
    tick(); expect_state("ar.reload1", 2, 1, 1);
    tick(); check("ar.1b.PO", int'(PO), 1);
`ifndef DOWN_TIMER_STICKY_DONE_EN
    check("ar.1b.done", int'(done), 0);
`endif
    tick(); check("ar.0b.PO", int'(PO), 0);
    tick(); expect_state("ar.reload2", 2, 1, 1);

    // Gating with en / borrowIn
    en = 1'b0;
    tick(); check("gate.en.PO", int'(PO), 2);
    check("gate.en.busy", int'(busy), 1);
    en = 1'b1; borrowIn = 1'b0;
    tick(); check("gate.bin.PO", int'(PO), 2);
    borrowIn = 1'b1;
    tick(); check("gate.run.PO", int'(PO), 1);
    tick(); check("gate.zero.PO", int'(PO), 0);
    check("gate.bo.on", int'(borrowOut), 1);
    en = 1'b0; #1;
    check("gate.bo.en0", int'(borrowOut), 0);
    en = 1'b1; borrowIn = 1'b0; #1;
    check("gate.bo.bin0", int'(borrowOut), 0);
    tick(); check("gate.hold0.PO", int'(PO), 0);
    borrowIn = 1'b1;

    // Simultaneous ld+start while running at PO=2
    PI = 3'd3; ld = 1'b1; start = 1'b1; mode = 1'b0;
    tick(); ld = 1'b0; start = 1'b0;
    tick(); expect_state("ls.pre", 2, 1, 0);
    PI = 3'd5; ld = 1'b1; start = 1'b1;
    tick(); expect_state("ls.post", 5, 1, 0);
    ld = 1'b0; start = 1'b0;
    tick(); expect_state("ls.dec", 4, 1, 0);

    // Asynchronous reset mid-count at PO=4
    #2 rst = 1'b0;
    #1;
    expect_state("arst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reload of zero: first decrement after start is terminal
    PI = 3'd0; ld = 1'b1;
    tick(); ld = 1'b0; start = 1'b1;
    tick(); expect_state("z.start", 0, 1, 0);
    start = 1'b0;
    tick(); expect_state("z.term", 0, 0, 1);
    tick();
`ifdef DOWN_TIMER_STICKY_DONE_EN
    expect_state("z.sticky", 0, 0, 1);
`else
    expect_state("z.pulse", 0, 0, 0);
`endif
    start = 1'b1;
    tick(); expect_state("z.restart", 0, 1, 0);
    start = 1'b0; en = 1'b0;

    // Two-stage cascade counting 63 down to 0
    c_PI = 3'd7; c_ld = 1'b1; c_start = 1'b1; c_en = 1'b1;
    tick();
    c_ld = 1'b0; c_start = 1'b0;
    for (int k = 63; k >= 0; k--) begin
      check($sformatf("casc.%0d", k), int'(hi_PO) * 8 + int'(lo_PO), k);
      if (k > 0) tick();
    end
    check("casc.hi.bo", int'(hi_bo), 1);
    tick();
    check("casc.end.hi.PO", int'(hi_PO), 0);
    check("casc.end.hi.busy", int'(hi_busy), 0);
    check("casc.end.hi.done", int'(hi_done), 1);
    check("casc.end.lo.PO", int'(lo_PO), 7);
    tick();
    check("casc.nowrap.hi.PO", int'(hi_PO), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
